// File: rtl/ats21_req_sequencer.sv
// ats21_req_sequencer: two-client instruction FIFOs feeding a split-phase ATS21 request FSM.
module ats21_req_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] head,
  output logic        full,
  output logic        avail
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign full  = cnt == CW'(DEPTH);
  assign avail = cnt != '0 || push;
  // An empty FIFO forwards the incoming word so a push and pop on the same edge pass it straight through
  assign head  = cnt != '0 ? mem[rp] : din;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

module ats21_req_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_instr,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_instr,
  output logic        b_ready,
  output logic        ats_req,
  output logic [15:0] ats_ctrlA,
  output logic [15:0] ats_ctrlB,
  input  logic        ats_ready,
  input  logic [1:0]  ats_stat,
  input  logic [23:0] ats_data,
  output logic        a_rsp_valid,
  output logic        b_rsp_valid,
  output logic [1:0]  rsp_stat,
  output logic [23:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, HI, LO, WAIT} state_t;
  state_t        state, nxt;
  logic [TW-1:0] wcnt;
  logic [31:0]   head_a, head_b, nl_a, nl_b;
  logic [15:0]   lo_a, lo_b;
  logic          part_a, part_b, full_a, full_b, avail_a, avail_b;
  logic          push_a, push_b, start, done;
  assign a_ready = !full_a && !reset;
  assign b_ready = !full_b && !reset;
  assign push_a  = a_valid && a_ready && a_instr[31:29] != 3'b000;
  assign push_b  = b_valid && b_ready && b_instr[31:29] != 3'b000;
  assign busy    = state != IDLE;
  ats21_req_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .reset(reset), .push(push_a), .pop(start && avail_a),
    .din(a_instr), .head(head_a), .full(full_a), .avail(avail_a)
  );
  ats21_req_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .reset(reset), .push(push_b), .pop(start && avail_b),
    .din(b_instr), .head(head_b), .full(full_b), .avail(avail_b)
  );
  always_comb begin
    start = state == IDLE && (avail_a || avail_b);
    done  = state == WAIT && (ats_ready || wcnt == TW'(TIMEOUT - 1));
    nl_a  = avail_a ? head_a : 32'h0;
    nl_b  = avail_b ? head_b : 32'h0;
    nxt   = start ? HI : state == HI ? LO : state == LO ? WAIT : done ? IDLE : state;
  end
  // Outputs are registered from the next state so the ATS21 side sees clean flop outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lo_a        <= '0;
      lo_b        <= '0;
      part_a      <= 1'b0;
      part_b      <= 1'b0;
      wcnt        <= '0;
      ats_req     <= 1'b0;
      ats_ctrlA   <= '0;
      ats_ctrlB   <= '0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      rsp_stat    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        lo_a   <= nl_a[15:0];
        lo_b   <= nl_b[15:0];
        part_a <= avail_a;
        part_b <= avail_b;
      end
      wcnt        <= state == WAIT ? wcnt + TW'(1) : '0;
      ats_req     <= start;
      ats_ctrlA   <= start ? nl_a[31:16] : state == HI ? lo_a : 16'h0;
      ats_ctrlB   <= start ? nl_b[31:16] : state == HI ? lo_b : 16'h0;
      a_rsp_valid <= done && part_a;
      b_rsp_valid <= done && part_b;
      if (done) begin
        rsp_stat    <= ats_ready ? ats_stat : 2'b11;
        rsp_data    <= ats_ready ? ats_data : 24'h0;
        rsp_timeout <= !ats_ready;
      end
    end
  end
endmodule

// File: tb/tb_ats21_req_sequencer.sv
// tb_ats21_req_sequencer: directed scenarios plus randomized traffic against a queue-based transaction model.
module tb_ats21_req_sequencer;
  localparam int TIMEOUT = 64;
  logic        clk = 1'b0, reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, ats_ready = 1'b0;
  logic [31:0] a_instr = '0, b_instr = '0;
  logic [1:0]  ats_stat = '0;
  logic [23:0] ats_data = '0;
  logic        a_ready, b_ready, ats_req, a_rsp_valid, b_rsp_valid, rsp_timeout, busy;
  logic [15:0] ats_ctrlA, ats_ctrlB;
  logic [1:0]  rsp_stat;
  logic [23:0] rsp_data;
  int n_cmp = 0, n_bad = 0;

  ats21_req_sequencer #(.TIMEOUT(TIMEOUT), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
    .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
    .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
    .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
    .rsp_stat(rsp_stat), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // What the DUT saw at each rising edge
  logic        acc_a = 1'b0, acc_b = 1'b0, smp_rdy = 1'b0;
  logic [31:0] acc_ia = '0, acc_ib = '0;
  logic [1:0]  smp_stat = '0;
  logic [23:0] smp_data = '0;
  always @(posedge clk) begin
    acc_a    <= a_valid && a_ready && !reset;
    acc_b    <= b_valid && b_ready && !reset;
    acc_ia   <= a_instr;
    acc_ib   <= b_instr;
    smp_rdy  <= ats_ready;
    smp_stat <= ats_stat;
    smp_data <= ats_data;
  end

  // Transaction model: pending client instructions per queue, one request in flight at a time
  logic [31:0] qa[$], qb[$];
  logic [31:0] la = '0, lb = '0;
  logic        pa = 1'b0, pb = 1'b0, prev_req = 1'b0, e_tmo = 1'b0;
  logic [1:0]  e_stat = '0;
  logic [23:0] e_data = '0;
  int phase = 0, w = 0, n_hi_a = 0, n_hi_b = 0;

  task automatic scoreboard();
    logic exp_start;
    if (reset) begin
      qa.delete(); qb.delete();
      phase = 0; pa = 0; pb = 0; prev_req = 0; e_stat = 0; e_data = 0; e_tmo = 0;
      n_cmp++;
      if ({ats_req, ats_ctrlA, ats_ctrlB, a_rsp_valid, b_rsp_valid, rsp_stat, rsp_data,
           rsp_timeout, busy, a_ready, b_ready} !== '0) begin
        n_bad++; $display("FAIL reset_outputs: req=%b ctrlA=%h ctrlB=%h busy=%b ready=%b%b, want all 0",
                          ats_req, ats_ctrlA, ats_ctrlB, busy, a_ready, b_ready);
      end
      return;
    end
    if (acc_a && acc_ia[31:29] != 3'b000) qa.push_back(acc_ia);
    if (acc_b && acc_ib[31:29] != 3'b000) qb.push_back(acc_ib);
    n_cmp++;
    if (prev_req && ats_req) begin n_bad++; $display("FAIL req_consecutive: ats_req high two cycles running"); end
    prev_req = ats_req;
    case (phase)
      0: begin
        exp_start = qa.size() > 0 || qb.size() > 0;
        n_cmp++;
        if (ats_req !== exp_start) begin n_bad++; $display("FAIL start: ats_req=%b want %b", ats_req, exp_start); end
        if (exp_start) begin
          pa = qa.size() > 0; pb = qb.size() > 0;
          la = 32'h0; lb = 32'h0;
          if (pa) begin la = qa.pop_front(); n_hi_a++; end
          if (pb) begin lb = qb.pop_front(); n_hi_b++; end
          n_cmp++;
          if ({ats_ctrlA, ats_ctrlB, busy} !== {la[31:16], lb[31:16], 1'b1}) begin
            n_bad++; $display("FAIL hi_ctrl: ctrlA=%h ctrlB=%h busy=%b want %h %h 1", ats_ctrlA, ats_ctrlB, busy, la[31:16], lb[31:16]);
          end
          phase = 1;
        end else begin
          n_cmp++;
          if ({ats_ctrlA, ats_ctrlB, busy, a_rsp_valid, b_rsp_valid} !== '0) begin
            n_bad++; $display("FAIL idle_out: ctrlA=%h ctrlB=%h busy=%b rsp=%b%b want all 0", ats_ctrlA, ats_ctrlB, busy, a_rsp_valid, b_rsp_valid);
          end
        end
      end
      1: begin
        n_cmp++;
        if ({ats_req, ats_ctrlA, ats_ctrlB, busy} !== {1'b0, la[15:0], lb[15:0], 1'b1}) begin
          n_bad++; $display("FAIL lo_ctrl: req=%b ctrlA=%h ctrlB=%h want 0 %h %h", ats_req, ats_ctrlA, ats_ctrlB, la[15:0], lb[15:0]);
        end
        phase = 2;
      end
      default: begin
        if (phase == 3 && (smp_rdy || w == TIMEOUT - 1)) begin
          e_stat = smp_rdy ? smp_stat : 2'b11;
          e_data = smp_rdy ? smp_data : 24'h0;
          e_tmo  = !smp_rdy;
          n_cmp++;
          if ({a_rsp_valid, b_rsp_valid, busy} !== {pa, pb, 1'b0}) begin
            n_bad++; $display("FAIL rsp_pulse: rsp=%b%b busy=%b want %b%b 0", a_rsp_valid, b_rsp_valid, busy, pa, pb);
          end
          phase = 0;
        end else begin
          n_cmp++;
          if ({ats_req, ats_ctrlA, ats_ctrlB, busy, a_rsp_valid, b_rsp_valid} !== {33'h0, 1'b1, 2'b00}) begin
            n_bad++; $display("FAIL wait_out: req=%b ctrlA=%h ctrlB=%h busy=%b rsp=%b%b", ats_req, ats_ctrlA, ats_ctrlB, busy, a_rsp_valid, b_rsp_valid);
          end
          w = phase == 2 ? 0 : w + 1;
          phase = 3;
        end
      end
    endcase
    n_cmp++;
    if ({rsp_stat, rsp_data, rsp_timeout} !== {e_stat, e_data, e_tmo}) begin
      n_bad++; $display("FAIL rsp_hold: stat=%b data=%h tmo=%b want %b %h %b", rsp_stat, rsp_data, rsp_timeout, e_stat, e_data, e_tmo);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    scoreboard();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    n_cmp++;
    if ({a_ready, b_ready, busy} !== 3'b110) begin
      n_bad++; $display("FAIL ready_after_reset: ready=%b%b busy=%b want 11 0", a_ready, b_ready, busy);
    end
  endtask

  // One transaction from an idle, empty DUT; d is the WAIT cycle carrying ats_ready (>= TIMEOUT means never)
  task automatic do_txn(input logic va, input logic [31:0] ia, input logic vb, input logic [31:0] ib,
                        input int d, input logic [1:0] st, input logic [23:0] dt);
    logic ea, eb;
    ea = va && ia[31:29] != 3'b000;
    eb = vb && ib[31:29] != 3'b000;
    a_valid = va; a_instr = ia; b_valid = vb; b_instr = ib;
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    if (!(ea || eb)) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if ({ats_req, busy, a_rsp_valid, b_rsp_valid} !== 4'b0) begin
          n_bad++; $display("FAIL nop_discard: req=%b busy=%b rsp=%b%b want 0", ats_req, busy, a_rsp_valid, b_rsp_valid);
        end
        cyc();
      end
      return;
    end
    n_cmp++;
    if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b1, ea ? ia[31:16] : 16'h0, eb ? ib[31:16] : 16'h0}) begin
      n_bad++; $display("FAIL txn_hi: req=%b ctrlA=%h ctrlB=%h", ats_req, ats_ctrlA, ats_ctrlB);
    end
    ats_ready = 1'b1; ats_stat = ~st; ats_data = ~dt;
    cyc();
    n_cmp++;
    if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b0, ea ? ia[15:0] : 16'h0, eb ? ib[15:0] : 16'h0}) begin
      n_bad++; $display("FAIL txn_lo: req=%b ctrlA=%h ctrlB=%h", ats_req, ats_ctrlA, ats_ctrlB);
    end
    cyc();
    for (int k = 0; k < TIMEOUT; k++) begin
      n_cmp++;
      if ({busy, a_rsp_valid, b_rsp_valid} !== 3'b100) begin
        n_bad++; $display("FAIL txn_wait: busy=%b rsp=%b%b at wait cycle %0d", busy, a_rsp_valid, b_rsp_valid, k);
      end
      ats_ready = k == d; ats_stat = st; ats_data = dt;
      cyc();
      ats_ready = 1'b0;
      if (k == d) break;
    end
    n_cmp++;
    if ({a_rsp_valid, b_rsp_valid, busy, rsp_stat, rsp_data, rsp_timeout} !==
        {ea, eb, 1'b0, d < TIMEOUT ? st : 2'b11, d < TIMEOUT ? dt : 24'h0, d >= TIMEOUT}) begin
      n_bad++; $display("FAIL txn_rsp: rsp=%b%b busy=%b stat=%b data=%h tmo=%b", a_rsp_valid, b_rsp_valid, busy, rsp_stat, rsp_data, rsp_timeout);
    end
    cyc();
    n_cmp++;
    if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL txn_pulse_width: rsp=%b%b want 00", a_rsp_valid, b_rsp_valid);
    end
  endtask

  task automatic test_single_a();
    do_txn(1'b1, 32'h2000_0000, 1'b0, 32'h0, 0, 2'b01, 24'h000123);
  endtask

  task automatic test_dual();
    do_txn(1'b1, 32'hA080_0090, 1'b1, 32'hAE00_0090, 2, 2'b10, 24'($urandom));
  endtask

  task automatic test_timeout();
    do_txn(1'b1, {3'b011, 29'($urandom)}, 1'b0, 32'h0, 1000, 2'b01, 24'h55AA55);
  endtask

  task automatic test_nop();
    do_txn(1'b1, {3'b000, 29'($urandom)}, 1'b1, {3'b000, 29'($urandom)}, 0, 2'b01, 24'h1);
  endtask

  task automatic test_reset_in_wait();
    a_valid = 1'b1; a_instr = {3'b101, 29'($urandom)};
    cyc();
    a_valid = 1'b0;
    repeat (4) cyc();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_setup: busy=%b want 1", busy); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_cmp++;
      if ({busy, a_rsp_valid, b_rsp_valid, rsp_timeout} !== 4'b0) begin
        n_bad++; $display("FAIL abort_no_rsp: busy=%b rsp=%b%b tmo=%b want 0", busy, a_rsp_valid, b_rsp_valid, rsp_timeout);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v[4];
    logic acc;
    int idx = 0, g = 0, t3 = 0, t4 = 0, base = n_hi_a;
    for (int i = 0; i < 4; i++) v[i] = {3'(i + 1), 29'($urandom)};
    a_valid = 1'b1; a_instr = v[0];
    while (idx < 4 && g < 500) begin
      acc = a_ready;
      cyc();
      g++;
      if (acc) begin
        idx++;
        if (idx == 3) begin
          t3 = g;
          n_cmp++;
          if (a_ready !== 1'b0) begin n_bad++; $display("FAIL full_after_two_held: a_ready=%b want 0", a_ready); end
        end
        if (idx == 4) t4 = g;
        a_valid = idx < 4;
        a_instr = idx < 4 ? v[idx] : 32'h0;
      end
    end
    a_valid = 1'b0;
    n_cmp++;
    if (t3 !== 3 || t4 !== TIMEOUT + 5) begin
      n_bad++; $display("FAIL accept_timing: third at %0d fourth at %0d, want 3 and %0d", t3, t4, TIMEOUT + 5);
    end
    g = 0;
    while ((busy || qa.size() > 0) && g < 600) begin cyc(); g++; end
    n_cmp++;
    if (n_hi_a - base !== 4 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_issued: %0d issued busy=%b, want 4 issued and idle", n_hi_a - base, busy);
    end
  endtask

  task automatic test_random();
    int g = 0, ba = n_hi_a, bb = n_hi_b;
    for (int c = 0; c < 1200; c++) begin
      a_valid = $urandom_range(0, 1) == 1;
      b_valid = $urandom_range(0, 2) == 0;
      a_instr = {3'($urandom_range(0, 7)), 29'($urandom)};
      b_instr = {3'($urandom_range(0, 7)), 29'($urandom)};
      ats_ready = $urandom_range(0, 5) == 0;
      ats_stat = 2'($urandom);
      ats_data = 24'($urandom);
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    while ((busy || qa.size() > 0 || qb.size() > 0) && g < 2000) begin
      ats_ready = $urandom_range(0, 3) == 0;
      cyc();
      g++;
    end
    ats_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || n_hi_a == ba || n_hi_b == bb) begin
      n_bad++; $display("FAIL random_drain: busy=%b issued a=%0d b=%0d", busy, n_hi_a - ba, n_hi_b - bb);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_dual();
    test_timeout();
    test_nop();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ats21_req_sequencer.md
ATS21_REQ_SEQUENCER -- requirements
Module: ats21_req_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the number of WAIT cycles before a request is abandoned.
REQ-002 SHALL have parameter DEPTH, default 2, the per-client instruction FIFO depth in entries.
REQ-003 SHALL use one clock; reset is synchronous and active-high (clk, reset).
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports a_valid, b_valid  in  1  client instruction valid.
REQ-007 SHALL have ports a_instr, b_instr  in  32  client instruction; [31:29] is the opcode.
REQ-008 SHALL have ports a_ready, b_ready  out  1  client FIFO can accept an instruction.
REQ-009 SHALL have port ats_req  out  1  ATS21 request strobe.
REQ-010 SHALL have ports ats_ctrlA, ats_ctrlB  out  16  ATS21 instruction halves.
REQ-011 SHALL have port ats_ready  in  1  ATS21 response valid.
REQ-012 SHALL have port ats_stat  in  2  ATS21 status.
REQ-013 SHALL have port ats_data  in  24  ATS21 response data.
REQ-014 SHALL have ports a_rsp_valid, b_rsp_valid  out  1  one-cycle response pulse per client.
REQ-015 SHALL have port rsp_stat  out  2  captured status.
REQ-016 SHALL have port rsp_data  out  24  captured data.
REQ-017 SHALL have port rsp_timeout  out  1  response was generated by timeout.
REQ-018 SHALL have port busy  out  1  FSM is not in IDLE.

Function
REQ-019 SHALL accept an instruction on a client edge where valid and ready are both 1; ready = FIFO not full.
REQ-020 SHALL discard an accepted instruction whose opcode is 3'b000, never enqueuing or issuing it.
REQ-021 SHALL implement FSM IDLE -> HI -> LO -> WAIT -> IDLE, with all ATS21-side outputs registered.
REQ-022 In IDLE, when either FIFO is non-empty, SHALL pop the head of each non-empty FIFO into its lane register and load 32'h0 (NOP) into each empty lane, then go to HI.
REQ-023 In HI, SHALL drive ats_req=1, ats_ctrlA=laneA[31:16], ats_ctrlB=laneB[31:16].
REQ-024 In LO, SHALL drive ats_req=0, ats_ctrlA=laneA[15:0], ats_ctrlB=laneB[15:0].
REQ-025 In WAIT and IDLE, SHALL drive ats_req=0 and ats_ctrlA=ats_ctrlB=16'h0.
REQ-026 SHALL ignore ats_ready outside WAIT.
REQ-027 In WAIT, on ats_ready=1, SHALL register ats_stat/ats_data into rsp_stat/rsp_data, set rsp_timeout=0, pulse rsp_valid for each lane that carried a client instruction, and return to IDLE.
REQ-028 SHALL count WAIT cycles from 0; on reaching TIMEOUT-1 without ats_ready, SHALL set rsp_stat=2'b11, rsp_data=0, rsp_timeout=1, pulse rsp_valid for the participating lanes, and return to IDLE.
REQ-029 SHALL hold rsp_stat/rsp_data/rsp_timeout stable until the next response.
REQ-030 SHALL guarantee at least one IDLE cycle (ats_req=0) between consecutive HI states, so ats_req is never high on two consecutive cycles.
REQ-031 Latency: ats_req SHALL be 1 on the cycle after the accepting edge when IDLE with empty FIFOs; the rsp_valid pulse SHALL be on the cycle after ats_ready is sampled.
REQ-032 If a push and a pop hit the same FIFO on the same edge, SHALL perform both, leaving the occupancy unchanged.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH, with no overflow (ready=0 when full) and no underflow (pop only when non-empty).
REQ-034 SHALL issue both lanes in one transaction when both FIFOs are non-empty in IDLE; a lane arriving after leaving IDLE waits for the next transaction.

Reset
REQ-035 On reset, SHALL go to IDLE, flush both FIFOs, clear lane registers and the timeout counter, and drive all outputs 0 (a_ready/b_ready=1 from the first cycle after reset is released).
REQ-036 Reset asserted in HI, LO or WAIT SHALL abort the transaction, producing no rsp_valid pulse for it.

Verification
REQ-037 A only, a_instr=32'h2000_0000 (set clock 0, 1X) -> HI: ats_ctrlA=16'h2000, ats_ctrlB=16'h0000, ats_req=1; LO: ats_ctrlA=16'h0000; ats_ready with stat=2'b01, data=24'h000123 -> a_rsp_valid=1 for one cycle, b_rsp_valid=0, rsp_stat=2'b01, rsp_data=24'h000123.
REQ-038 A=32'hA080_0090 and B=32'hAE00_0090 on the same edge -> one transaction: HI ctrlA=16'hA080, ctrlB=16'hAE00; LO ctrlA=ctrlB=16'h0090; both rsp_valid pulse together.
REQ-039 Three A instructions pushed back-to-back with DEPTH=2 and ats_ready withheld -> a_ready=0 after two held, the third accepted only after the first pop, all three issued in order, and ats_req never high on two consecutive cycles.
REQ-040 ats_ready held 0 -> after 64 WAIT cycles: rsp_timeout=1, rsp_stat=2'b11, rsp_data=0, FSM back in IDLE.
REQ-041 Opcode-000 instruction accepted -> no ats_req and no rsp_valid; reset asserted in WAIT -> busy=0 and no response pulse.
